// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// and captures the returned word into the F/D pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_fd_valid,
  output logic [31:0] o_fd_inst,
  output logic [31:0] o_fd_pc,
  output logic [31:0] o_fd_pc4,
  output logic        o_halted,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_inst_q, fd_inst_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_pc4_q, fd_pc4_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  // Target alignment is the redirecting stage's job; low bits are simply dropped.
  logic        unused_redirect_lsb;
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fd_valid_d = fd_valid_q;
    fd_inst_d  = fd_inst_q;
    fd_pc_d    = fd_pc_q;
    fd_pc4_d   = fd_pc4_q;
    count_d    = count_q;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_d       = RESET_ADDR;
        fd_valid_d = 1'b0;
      end
      RUN: begin
        // Priority: halt, then redirect, then stall, then normal fetch.
        if (i_halt) begin
          state_d    = HALT;
          fd_valid_d = 1'b0;
        end else if (i_redirect) begin
          pc_d       = {i_redirect_pc[31:2], 2'b00};
          fd_valid_d = 1'b0;
        end else if (!i_stall) begin
          pc_d       = pc_plus4;
          fd_valid_d = 1'b1;
          fd_inst_d  = i_imem_rdata;
          fd_pc_d    = pc_q;
          fd_pc4_d   = pc_plus4;
          count_d    = count_q + 32'd1;
        end
      end
      HALT: begin
        fd_valid_d = 1'b0;
      end
      default: begin
        state_d    = BOOT;
        pc_d       = RESET_ADDR;
        fd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_ADDR;
      fd_valid_q <= 1'b0;
      fd_inst_q  <= '0;
      fd_pc_q    <= '0;
      fd_pc4_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fd_valid_q <= fd_valid_d;
      fd_inst_q  <= fd_inst_d;
      fd_pc_q    <= fd_pc_d;
      fd_pc4_q   <= fd_pc4_d;
      count_q    <= count_d;
    end
  end

  assign o_imem_raddr  = pc_q;
  assign o_fd_valid    = fd_valid_q;
  assign o_fd_inst     = fd_inst_q;
  assign o_fd_pc       = fd_pc_q;
  assign o_fd_pc4      = fd_pc4_q;
  assign o_fetch_count = count_q;
  assign o_halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table through a scoreboard queue,
// plus hand-written asynchronous-reset sequences.
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_ADDR = 32'h00000000;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] o_imem_raddr;
  logic [31:0] i_imem_rdata;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic        o_fd_valid;
  logic [31:0] o_fd_inst;
  logic [31:0] o_fd_pc;
  logic [31:0] o_fd_pc4;
  logic        o_halted;
  logic [31:0] o_fetch_count;

  fetch_unit #(.RESET_ADDR(TB_RESET_ADDR)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_raddr  (o_imem_raddr),
    .i_imem_rdata  (i_imem_rdata),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_halt        (i_halt),
    .o_fd_valid    (o_fd_valid),
    .o_fd_inst     (o_fd_inst),
    .o_fd_pc       (o_fd_pc),
    .o_fd_pc4      (o_fd_pc4),
    .o_halted      (o_halted),
    .o_fetch_count (o_fetch_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Instruction memory: address-dependent word, 0x13 (nop) at address 0.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  assign i_imem_rdata = inst_of(o_imem_raddr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic [31:0] raddr;
    logic        valid;
    logic [31:0] fpc;
    logic [31:0] fpc4;
    logic [31:0] finst;
    logic [31:0] cnt;
    logic        halted;
  } vec_t;

  vec_t vecs[16];
  vec_t sb_q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                              input logic [31:0] rpc, input logic halt,
                              input logic [31:0] raddr, input logic valid,
                              input logic [31:0] fpc, input logic [31:0] fpc4,
                              input logic [31:0] finst, input logic [31:0] cnt,
                              input logic halted);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.halt = halt;
    v.raddr = raddr; v.valid = valid; v.fpc = fpc; v.fpc4 = fpc4;
    v.finst = finst; v.cnt = cnt; v.halted = halted;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    i_rst = v.rst; i_stall = v.stall; i_redirect = v.redir;
    i_redirect_pc = v.rpc; i_halt = v.halt;
    sb_q.push_back(v);
  endtask

  task automatic check_pop(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      total++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    cmp({tag, " raddr"},  o_imem_raddr,          e.raddr);
    cmp({tag, " valid"},  {31'd0, o_fd_valid},   {31'd0, e.valid});
    cmp({tag, " fd_pc"},  o_fd_pc,               e.fpc);
    cmp({tag, " fd_pc4"}, o_fd_pc4,              e.fpc4);
    cmp({tag, " fd_inst"}, o_fd_inst,            e.finst);
    cmp({tag, " count"},  o_fetch_count,         e.cnt);
    cmp({tag, " halted"}, {31'd0, o_halted},     {31'd0, e.halted});
  endtask

  // Expected state after reset with no clock edge involved.
  function automatic vec_t rst_exp(input logic stall, input logic redir, input logic halt);
    return mk(1'b1, stall, redir, 32'h0000_0200, halt,
              TB_RESET_ADDR, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    string tag;
    i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_halt = 1'b0;

    //              rst   stl   red   rpc            hlt   raddr          v     fd_pc          fd_pc4         fd_inst                 cnt  h
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,                  0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,                  0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 32'h0,         32'h4,         32'h00000013,           1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4,         32'h8,         inst_of(32'h4),         2, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4,         32'h8,         inst_of(32'h4),         2, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4,         32'h8,         inst_of(32'h4),         2, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4,         32'h8,         inst_of(32'h4),         2, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'hC,         1'b1, 32'h8,         32'hC,         inst_of(32'h8),         3, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 32'h103,       1'b0, 32'h100,       1'b0, 32'h8,         32'hC,         inst_of(32'h8),         3, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h104,       1'b1, 32'h100,       32'h104,       inst_of(32'h100),       4, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,  1'b0, 32'hFFFFFFFC,  1'b0, 32'h100,       32'h104,       inst_of(32'h100),       4, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFFFFFC,  32'h0,         32'hFFFFFC13,           5, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 32'h200,       1'b1, 32'h0,         1'b0, 32'hFFFFFFFC,  32'h0,         32'hFFFFFC13,           5, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 32'h300,       1'b0, 32'h0,         1'b0, 32'hFFFFFFFC,  32'h0,         32'hFFFFFC13,           5, 1'b1);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hFFFFFFFC,  32'h0,         32'hFFFFFC13,           5, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hFFFFFFFC,  32'h0,         32'hFFFFFC13,           5, 1'b1);

    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      drive(vecs[i]);
      @(posedge i_clk);
      #1;
      tag = $sformatf("vec%0d", i);
      check_pop(tag);
    end

    // Asynchronous reset out of HALT, observed between edges.
    @(negedge i_clk);
    #2;
    drive(rst_exp(1'b1, 1'b1, 1'b1));
    #1;
    check_pop("async_rst_halt");

    // Inputs ignored while reset is held across an edge.
    @(posedge i_clk);
    #1;
    sb_q.push_back(rst_exp(1'b1, 1'b1, 1'b1));
    check_pop("rst_held");

    // Release: BOOT edge, then five captures from RESET_ADDR.
    @(negedge i_clk);
    drive(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, TB_RESET_ADDR, 1'b0,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    @(posedge i_clk);
    #1;
    check_pop("boot");
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] pc;
      pc = TB_RESET_ADDR + 32'(4 * (k - 1));
      @(negedge i_clk);
      drive(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, pc + 32'd4, 1'b1,
               pc, pc + 32'd4, inst_of(pc), 32'(k), 1'b0));
      @(posedge i_clk);
      #1;
      tag = $sformatf("run%0d", k);
      check_pop(tag);
    end

    // Asynchronous reset in RUN with count=5, checked before the next edge.
    @(negedge i_clk);
    #2;
    drive(rst_exp(1'b0, 1'b0, 1'b0));
    #1;
    check_pop("async_rst_run");

    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
